// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED position controller: display modes, position width helper
// and synchroniser depth.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_BAR    = 2'b01,
    MODE_BINARY = 2'b10,
    MODE_BLANK  = 2'b11
  } led_mode_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Position width: max(1, clog2(n)).
  function automatic int unsigned pos_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw active-low button to single-cycle step pulses: 2-flop synchroniser, debouncer and
// hold-to-repeat generator.
module button_conditioner
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic step
);

  localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW     = $clog2(RepMax + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   sync_lvl;
  logic                   sync_vld;

  logic          deb_q;
  logic          deb_prev_q;
  logic [DW-1:0] deb_cnt_q;

  logic          armed_q;
  logic          rep_on_q;
  logic          rep_first_q;
  logic [RW-1:0] rep_cnt_q;
  logic [RW-1:0] rep_thr;
  logic          step_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign sync_vld = vld_q[SYNC_STAGES-1];
  assign rep_thr  = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
  assign step     = step_q;

  // vld_q marks when the synchroniser holds real samples rather than reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
    end else if (sync_lvl != deb_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES)) begin
        deb_q     <= sync_lvl;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  // A press only counts once a genuine release has been seen since reset, so a button
  // held through reset stays silent until it is released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
      rep_on_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      step_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      step_q     <= 1'b0;
      if (sync_vld && sync_lvl) begin
        armed_q <= 1'b1;
      end
      if (!deb_q) begin
        if (deb_prev_q) begin
          if (armed_q) begin
            step_q      <= 1'b1;
            rep_on_q    <= 1'b1;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= RW'(1);
          end
        end else if (rep_on_q && (REPEAT_DELAY != 0)) begin
          if (rep_cnt_q == rep_thr) begin
            step_q      <= 1'b1;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= RW'(1);
          end else begin
            rep_cnt_q <= rep_cnt_q + RW'(1);
          end
        end
      end else begin
        rep_on_q    <= 1'b0;
        rep_first_q <= 1'b0;
        rep_cnt_q   <= '0;
      end
    end
  end

endmodule

// File: rtl/led_position_ctrl.sv
// Button-driven LED position controller: position register with wrap/saturate stepping and a
// registered LED decode in one-hot, bar, binary or blank mode.
module led_position_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned LED_COUNT       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          WRAP            = 1'b1,
  localparam int unsigned PW             = pos_width(LED_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button_inc,
  input  logic                 button_dec,
  input  logic [1:0]           mode,
  output logic [LED_COUNT-1:0] led,
  output logic [PW-1:0]        position
);

  localparam logic [PW-1:0] PosMax = PW'(LED_COUNT - 1);

  logic                 inc_step;
  logic                 dec_step;
  logic [PW-1:0]        pos_q;
  logic [PW-1:0]        pos_d;
  logic [LED_COUNT-1:0] led_q;
  logic [LED_COUNT-1:0] led_d;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_inc (
    .clk   (clk),
    .reset (reset),
    .button(button_inc),
    .step  (inc_step)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dec (
    .clk   (clk),
    .reset (reset),
    .button(button_dec),
    .step  (dec_step)
  );

  // Simultaneous inc and dec cancel out.
  always_comb begin
    pos_d = pos_q;
    case ({inc_step, dec_step})
      2'b10:   pos_d = (pos_q == PosMax) ? (WRAP ? '0 : pos_q) : pos_q + PW'(1);
      2'b01:   pos_d = (pos_q == '0) ? (WRAP ? PosMax : pos_q) : pos_q - PW'(1);
      default: pos_d = pos_q;
    endcase
  end

  always_comb begin
    led_d = '0;
    case (led_mode_e'(mode))
      MODE_ONEHOT: begin
        for (int unsigned i = 0; i < LED_COUNT; i++) led_d[i] = (i == 32'(pos_q));
      end
      MODE_BAR: begin
        for (int unsigned i = 0; i < LED_COUNT; i++) led_d[i] = (i <= 32'(pos_q));
      end
      MODE_BINARY: led_d[PW-1:0] = pos_q;
      default:     led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= '0;
      led_q <= '0;
    end else begin
      pos_q <= pos_d;
      led_q <= led_d;
    end
  end

  assign led      = led_q;
  assign position = pos_q;

endmodule

// File: tb/tb_led_position_ctrl.sv
// Directed bench for led_position_ctrl: stepping latency, glitch rejection, wrap/saturate,
// auto-repeat timing, display modes and reset during a held press.
module tb_led_position_ctrl;

  logic       clk;
  logic       reset;
  logic       bi [3];
  logic       bd [3];
  logic [1:0] md [3];

  logic [7:0] led8, led8s;
  logic [2:0] pos8, pos8s;
  logic [4:0] led5;
  logic [2:0] pos5;

  int checks = 0;
  int errors = 0;

  led_position_ctrl #(
    .LED_COUNT(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .WRAP(1'b1)
  ) dut8 (
    .clk(clk), .reset(reset), .button_inc(bi[0]), .button_dec(bd[0]), .mode(md[0]),
    .led(led8), .position(pos8)
  );

  led_position_ctrl #(
    .LED_COUNT(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .WRAP(1'b0)
  ) dut8s (
    .clk(clk), .reset(reset), .button_inc(bi[1]), .button_dec(bd[1]), .mode(md[1]),
    .led(led8s), .position(pos8s)
  );

  led_position_ctrl #(
    .LED_COUNT(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .WRAP(1'b1)
  ) dut5 (
    .clk(clk), .reset(reset), .button_inc(bi[2]), .button_dec(bd[2]), .mode(md[2]),
    .led(led5), .position(pos5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the selected raw buttons low for 10 edges, then release and let it settle.
  task automatic press(input int idx, input bit inc, input bit dec);
    @(negedge clk);
    if (inc) bi[idx] = 1'b0;
    if (dec) bd[idx] = 1'b0;
    repeat (10) @(negedge clk);
    bi[idx] = 1'b1;
    bd[idx] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  int          t_chg[$];
  int          exp_t[5] = '{8, 28, 33, 38, 43};
  logic [2:0]  prev_pos;

  initial begin
    for (int i = 0; i < 3; i++) begin
      bi[i] = 1'b1;
      bd[i] = 1'b1;
      md[i] = 2'b00;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pos", 64'(pos8), 64'd0);
    check("reset_led", 64'(led8), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("first_led_onehot0", 64'(led8), 64'h01);
    repeat (4) @(negedge clk);

    // First press with latency checks: position lands on edge 8, led on edge 9.
    bi[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("lat_before_edge8", 64'(pos8), 64'd0);
    @(negedge clk);
    check("lat_pos_edge8", 64'(pos8), 64'd1);
    @(negedge clk);
    check("lat_led_edge9", 64'(led8), 64'h02);
    bi[0] = 1'b1;
    repeat (12) @(negedge clk);
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    check("three_inc_pos", 64'(pos8), 64'd3);
    check("three_inc_led", 64'(led8), 64'h08);

    // 3-cycle glitch is shorter than the debounce window.
    @(negedge clk);
    bi[0] = 1'b0;
    repeat (3) @(negedge clk);
    bi[0] = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_pos", 64'(pos8), 64'd3);

    press(0, 1'b1, 1'b1);
    check("simul_pos", 64'(pos8), 64'd3);

    press(0, 1'b0, 1'b1);
    press(0, 1'b0, 1'b1);
    press(0, 1'b0, 1'b1);
    check("dec_to0_pos", 64'(pos8), 64'd0);
    press(0, 1'b0, 1'b1);
    check("wrap_dec_pos", 64'(pos8), 64'd7);
    check("wrap_dec_led", 64'(led8), 64'h80);
    press(0, 1'b1, 1'b0);
    check("wrap_inc_pos", 64'(pos8), 64'd0);

    // Auto-repeat: raw low for 40 edges keeps debounced press for 40 cycles.
    @(negedge clk);
    bi[0] = 1'b0;
    prev_pos = pos8;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (pos8 != prev_pos) t_chg.push_back(c);
      prev_pos = pos8;
      if (c == 39) bi[0] = 1'b1;
    end
    check("rep_count", 64'(t_chg.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < t_chg.size()) check($sformatf("rep_time%0d", k), 64'(t_chg[k]), 64'(exp_t[k]));
    end
    check("rep_pos", 64'(pos8), 64'd5);
    check("rep_led", 64'(led8), 64'h20);

    // Saturating instance.
    press(1, 1'b0, 1'b1);
    check("sat_dec_pos", 64'(pos8s), 64'd0);
    for (int k = 0; k < 7; k++) press(1, 1'b1, 1'b0);
    check("sat_up7_pos", 64'(pos8s), 64'd7);
    press(1, 1'b1, 1'b0);
    check("sat_inc_pos", 64'(pos8s), 64'd7);
    check("sat_inc_led", 64'(led8s), 64'h80);

    // Display modes on the 5-LED instance.
    md[2] = 2'b01;
    press(2, 1'b1, 1'b0);
    press(2, 1'b1, 1'b0);
    press(2, 1'b1, 1'b0);
    check("m5_pos3", 64'(pos5), 64'd3);
    check("m5_bar", 64'(led5), 64'b01111);
    md[2] = 2'b10;
    @(negedge clk);
    check("m5_binary", 64'(led5), 64'b00011);
    md[2] = 2'b11;
    @(negedge clk);
    check("m5_blank", 64'(led5), 64'd0);
    press(2, 1'b1, 1'b0);
    check("m5_blank_pos4", 64'(pos5), 64'd4);
    check("m5_blank_led", 64'(led5), 64'd0);
    md[2] = 2'b00;
    @(negedge clk);
    check("m5_onehot4", 64'(led5), 64'b10000);
    press(2, 1'b1, 1'b0);
    check("m5_wrap_pos", 64'(pos5), 64'd0);
    check("m5_wrap_led", 64'(led5), 64'b00001);

    // Reset in the middle of a held, repeating press.
    @(negedge clk);
    bi[0] = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_pos", 64'(pos8), 64'd0);
    check("rst_mid_led", 64'(led8), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("held_after_rst_pos", 64'(pos8), 64'd0);
    check("held_after_rst_led", 64'(led8), 64'h01);
    bi[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("release_after_rst_pos", 64'(pos8), 64'd0);
    press(0, 1'b1, 1'b0);
    check("repress_pos", 64'(pos8), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
